czonotope_loader: RTL and testbench

Sequencer that fills a `CZonotope` register set (dimensions `n`/`ng`/`nc`, center `c`, generators `G`, constraints `A`, `b`) from a single-word valid/ready stream. On a start command it validates the requested dimensions and clears the set. It then walks c, G, A, b in a fixed order, writing one word per accepted beat. It sits between the host/DMA word stream and any CZonotope-consuming operator, and presents the loaded set through the `CZonotope.out` modport.

---
 rtl/czonotope_loader_if.sv | 17 +
 rtl/czonotope_loader.sv | 90 +++++++++
 tb/tb_czonotope_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/czonotope_loader_if.sv
// czonotope_if: loaded constrained-zonotope register set (dims, c, g, a, b)
interface CZonotope #(
  parameter int DATA_WIDTH = 32,
  parameter int NMAX = 3,
  parameter int NGMAX = 15,
  parameter int NCMAX = 12
);
  logic [$clog2(NMAX):0] n;
  logic [$clog2(NGMAX):0] ng;
  logic [$clog2(NCMAX):0] nc;
  logic [DATA_WIDTH-1:0] c [NMAX];
  logic [DATA_WIDTH-1:0] g [NMAX][NGMAX];
  logic [DATA_WIDTH-1:0] a [NCMAX][NGMAX];
  logic [DATA_WIDTH-1:0] b [NCMAX];
  modport out (output n, ng, nc, c, g, a, b);
  modport in (input n, ng, nc, c, g, a, b);
endinterface

// File: rtl/czonotope_loader.sv
// czonotope_loader: fills a CZonotope register set from a valid/ready word stream
module czonotope_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int NMAX = 3,
  parameter int NGMAX = 15,
  parameter int NCMAX = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [$clog2(NMAX):0] n_in,
  input  logic [$clog2(NGMAX):0] ng_in,
  input  logic [$clog2(NCMAX):0] nc_in,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic s_valid,
  output logic s_ready,
  output logic busy,
  output logic done,
  output logic err,
  CZonotope.out zono
);
  localparam int NW = $clog2(NMAX) + 1;
  localparam int GW = $clog2(NGMAX) + 1;
  localparam int KW = $clog2(NCMAX) + 1;
  localparam int RMAX = NMAX > NCMAX ? NMAX : NCMAX;
  localparam int CMAX = RMAX > NGMAX ? RMAX : NGMAX;
  localparam int IW = $clog2(RMAX + 1);
  localparam int JW = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, LOAD_C, LOAD_G, LOAD_A, LOAD_B} state_t;
  state_t state, state_n;
  logic [IW-1:0] row;
  logic [JW-1:0] col, lim;
  logic legal, clr, beat, last_col, last_row, adv, fin;
  assign legal = (n_in != '0) && (n_in <= NW'(NMAX)) && (ng_in <= GW'(NGMAX)) &&
                 (nc_in <= KW'(NCMAX)) && !(ng_in == '0 && nc_in != '0);
  assign clr = (state == IDLE) && start && legal;
  assign s_ready = state != IDLE;
  assign busy = state != IDLE;
  assign beat = s_valid && s_ready;
  // c and b are single rows; g and a walk row-major over ng columns
  always_comb begin
    lim = state == LOAD_C ? JW'(zono.n) : state == LOAD_B ? JW'(zono.nc) : JW'(zono.ng);
    last_row = state == LOAD_G ? row == IW'(zono.n) - 1'b1 :
               state == LOAD_A ? row == IW'(zono.nc) - 1'b1 : 1'b1;
    last_col = col == lim - 1'b1;
    adv = beat && last_col && last_row;
    state_n = state;
    if (clr) state_n = LOAD_C;
    else if (adv)
      state_n = state == LOAD_C ? (zono.ng != '0 ? LOAD_G : IDLE) :
                state == LOAD_G ? (zono.nc != '0 ? LOAD_A : IDLE) :
                state == LOAD_A ? LOAD_B : IDLE;
    fin = adv && state_n == IDLE;
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
    done <= !rst && fin;
    err <= !rst && state == IDLE && start && !legal;
    if (rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (beat) begin
      col <= last_col ? '0 : col + 1'b1;
      row <= !last_col ? row : last_row ? '0 : row + 1'b1;
    end
    if (rst) begin
      zono.n <= '0;
      zono.ng <= '0;
      zono.nc <= '0;
    end else if (clr) begin
      zono.n <= n_in;
      zono.ng <= ng_in;
      zono.nc <= nc_in;
    end
    for (int i = 0; i < NMAX; i++) begin
      if (rst || clr) zono.c[i] <= '0;
      else if (beat && state == LOAD_C && col == JW'(i)) zono.c[i] <= s_data;
      for (int j = 0; j < NGMAX; j++)
        if (rst || clr) zono.g[i][j] <= '0;
        else if (beat && state == LOAD_G && row == IW'(i) && col == JW'(j)) zono.g[i][j] <= s_data;
    end
    for (int i = 0; i < NCMAX; i++) begin
      if (rst || clr) zono.b[i] <= '0;
      else if (beat && state == LOAD_B && col == JW'(i)) zono.b[i] <= s_data;
      for (int j = 0; j < NGMAX; j++)
        if (rst || clr) zono.a[i][j] <= '0;
        else if (beat && state == LOAD_A && row == IW'(i) && col == JW'(j)) zono.a[i][j] <= s_data;
    end
  end
endmodule

// File: tb/tb_czonotope_loader.sv
// tb_czonotope_loader: directed tests of the CZonotope stream loader
module tb_czonotope_loader;
  logic clk = 1'b0;
  logic rst, start, s_valid, s_ready, busy, done, err;
  logic [2:0] n_in;
  logic [4:0] ng_in, nc_in;
  logic [31:0] s_data;
  int beats = 0, beat0 = 0, checks = 0, errors = 0;

  CZonotope #(.DATA_WIDTH(32), .NMAX(3), .NGMAX(15), .NCMAX(12)) zono();

  czonotope_loader dut (
    .clk(clk), .rst(rst), .start(start), .n_in(n_in), .ng_in(ng_in), .nc_in(nc_in),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .busy(busy), .done(done),
    .err(err), .zono(zono)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (s_valid && s_ready) beats <= beats + 1;
  assign s_data = 32'(beats - beat0 + 1);

  // flat element index e: c[0..2], g[0..44], a[0..179], b[0..11]
  function automatic logic [31:0] dut_word(int e);
    if (e < 3) return zono.c[e];
    if (e < 48) return zono.g[(e - 3) / 15][(e - 3) % 15];
    if (e < 228) return zono.a[(e - 48) / 15][(e - 48) % 15];
    return zono.b[e - 228];
  endfunction

  function automatic logic [31:0] exp_word(int e, int n, int ng, int nc);
    int i, j;
    if (e < 3) return e < n ? 32'(e + 1) : 32'd0;
    if (e < 48) begin
      i = (e - 3) / 15; j = (e - 3) % 15;
      return (i < n && j < ng) ? 32'(n + i * ng + j + 1) : 32'd0;
    end
    if (e < 228) begin
      i = (e - 48) / 15; j = (e - 48) % 15;
      return (i < nc && j < ng) ? 32'(n + n * ng + i * ng + j + 1) : 32'd0;
    end
    i = e - 228;
    return i < nc ? 32'(n + n * ng + nc * ng + i + 1) : 32'd0;
  endfunction

  // lat counts cycles after the start edge: the cycle right after it is 1
  task automatic run_load(input int n, input int ng, input int nc, input bit tog, input bit now,
                          input int mid, output int lat, output bit up);
    if (!now) @(negedge clk);
    n_in = 3'(n); ng_in = 5'(ng); nc_in = 5'(nc); start = 1'b1; s_valid = 1'b0; beat0 = beats;
    @(negedge clk);
    start = 1'b0; up = busy && s_ready; s_valid = 1'b1; lat = -1;
    for (int k = 2; k <= 400; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      s_valid = !tog || ((k - 1) % 3 == 0);
      start = k == mid;
      if (k == mid) begin n_in = 3'd1; ng_in = 5'd1; nc_in = 5'd0; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; n_in = '0; ng_in = '0; nc_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_ready, busy, done, err} !== 4'b0) begin
      errors++; $display("FAIL reset_outputs got %b want 0000", {s_ready, busy, done, err});
    end
    checks++;
    if ({zono.n, zono.ng, zono.nc} !== 13'd0) begin
      errors++; $display("FAIL reset_dims got %0d/%0d/%0d want 0/0/0", zono.n, zono.ng, zono.nc);
    end
    for (int e = 0; e < 240; e++) begin
      checks++;
      if (dut_word(e) !== 32'd0) begin errors++; $display("FAIL reset_entry %0d got %0d want 0", e, dut_word(e)); end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat; bit up;
    run_load(2, 3, 1, 1'b0, 1'b0, 0, lat, up);
    s_valid = 1'b1;
    repeat (2) @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (!up) begin errors++; $display("FAIL basic_busy_at_t1 got %0b want 1", up); end
    checks++;
    if (lat != 13) begin errors++; $display("FAIL basic_latency got %0d want 13", lat); end
    checks++;
    if (beats - beat0 != 12) begin errors++; $display("FAIL basic_words_consumed got %0d want 12", beats - beat0); end
    checks++;
    if (zono.c[1] !== 32'd2 || zono.g[1][2] !== 32'd8 || zono.a[0][2] !== 32'd11 || zono.b[0] !== 32'd12) begin
      errors++; $display("FAIL basic_spot got %0d %0d %0d %0d want 2 8 11 12", zono.c[1], zono.g[1][2], zono.a[0][2], zono.b[0]);
    end
    for (int e = 0; e < 240; e++) begin
      checks++;
      if (dut_word(e) !== exp_word(e, 2, 3, 1)) begin
        errors++; $display("FAIL basic_entry %0d got %0d want %0d", e, dut_word(e), exp_word(e, 2, 3, 1));
      end
    end
  endtask

  task automatic test_stall;
    int lat; bit up;
    run_load(2, 3, 1, 1'b1, 1'b0, 0, lat, up);
    s_valid = 1'b0;
    checks++;
    if (lat != 35) begin errors++; $display("FAIL stall_latency got %0d want 35", lat); end
    checks++;
    if (beats - beat0 != 12) begin errors++; $display("FAIL stall_words_consumed got %0d want 12", beats - beat0); end
    for (int e = 0; e < 240; e++) begin
      checks++;
      if (dut_word(e) !== exp_word(e, 2, 3, 1)) begin
        errors++; $display("FAIL stall_entry %0d got %0d want %0d", e, dut_word(e), exp_word(e, 2, 3, 1));
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat; bit up;
    run_load(3, 2, 0, 1'b0, 1'b0, 0, lat, up);
    checks++;
    if (lat != 10) begin errors++; $display("FAIL skip_latency got %0d want 10", lat); end
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_cycle_ready got %0b/%0b want 0/0", s_ready, busy);
    end
    for (int e = 0; e < 240; e++) begin
      checks++;
      if (dut_word(e) !== exp_word(e, 3, 2, 0)) begin
        errors++; $display("FAIL skip_entry %0d got %0d want %0d", e, dut_word(e), exp_word(e, 3, 2, 0));
      end
    end
    run_load(3, 0, 0, 1'b0, 1'b1, 0, lat, up);
    s_valid = 1'b0;
    checks++;
    if (lat != 4 || !up) begin errors++; $display("FAIL b2b_latency got %0d/%0b want 4/1", lat, up); end
    for (int e = 0; e < 240; e++) begin
      checks++;
      if (dut_word(e) !== exp_word(e, 3, 0, 0)) begin
        errors++; $display("FAIL b2b_entry %0d got %0d want %0d", e, dut_word(e), exp_word(e, 3, 0, 0));
      end
    end
  endtask

  task automatic test_illegal;
    int tn[4] = '{0, 4, 3, 3};
    int tg[4] = '{2, 2, 16, 0};
    int tc[4] = '{1, 1, 1, 2};
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      n_in = 3'(tn[t]); ng_in = 5'(tg[t]); nc_in = 5'(tc[t]); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({err, done, busy, s_ready} !== 4'b1000) begin
        errors++; $display("FAIL illegal_%0d_pulse got %b want 1000", t, {err, done, busy, s_ready});
      end
      @(negedge clk);
      checks++;
      if ({err, busy} !== 2'b00) begin errors++; $display("FAIL illegal_%0d_after got %b want 00", t, {err, busy}); end
    end
    checks++;
    if (zono.n !== 3'd3 || zono.ng !== 5'd0 || zono.nc !== 5'd0) begin
      errors++; $display("FAIL illegal_dims got %0d/%0d/%0d want 3/0/0", zono.n, zono.ng, zono.nc);
    end
    for (int e = 0; e < 240; e++) begin
      checks++;
      if (dut_word(e) !== exp_word(e, 3, 0, 0)) begin
        errors++; $display("FAIL illegal_entry %0d got %0d want %0d", e, dut_word(e), exp_word(e, 3, 0, 0));
      end
    end
  endtask

  task automatic test_reset_midload;
    @(negedge clk);
    n_in = 3'd3; ng_in = 5'd15; nc_in = 5'd12; start = 1'b1; beat0 = beats;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (beats - beat0 != 100 || busy !== 1'b1) begin
      errors++; $display("FAIL midload_progress got %0d/%0b want 100/1", beats - beat0, busy);
    end
    rst = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_ready, busy, done, err} !== 4'b0 || {zono.n, zono.ng, zono.nc} !== 13'd0) begin
      errors++; $display("FAIL midload_reset got %b dims %0d/%0d/%0d want 0000 0/0/0",
                        {s_ready, busy, done, err}, zono.n, zono.ng, zono.nc);
    end
    for (int e = 0; e < 240; e++) begin
      checks++;
      if (dut_word(e) !== 32'd0) begin errors++; $display("FAIL midload_entry %0d got %0d want 0", e, dut_word(e)); end
    end
    rst = 1'b0;
  endtask

  task automatic test_full;
    int lat; bit up;
    run_load(3, 15, 12, 1'b0, 1'b0, 50, lat, up);
    s_valid = 1'b0; start = 1'b0;
    checks++;
    if (lat != 241) begin errors++; $display("FAIL full_latency got %0d want 241", lat); end
    checks++;
    if (zono.n !== 3'd3 || zono.ng !== 5'd15 || zono.nc !== 5'd12) begin
      errors++; $display("FAIL full_dims got %0d/%0d/%0d want 3/15/12", zono.n, zono.ng, zono.nc);
    end
    checks++;
    if (zono.b[11] !== 32'd240) begin errors++; $display("FAIL full_last got %0d want 240", zono.b[11]); end
    for (int e = 0; e < 240; e++) begin
      checks++;
      if (dut_word(e) !== exp_word(e, 3, 15, 12)) begin
        errors++; $display("FAIL full_entry %0d got %0d want %0d", e, dut_word(e), exp_word(e, 3, 15, 12));
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_back_to_back;
    test_illegal;
    test_reset_midload;
    test_full;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
